// File: rtl/mmu_ctrl.sv
// Command sequencer for a matrix-multiply unit: weight load, optional swap, multiply.
// Also provides stream pass-throughs and a saturating count of unread results.
module mmu_ctrl #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       busy,
  output logic       err,
  input  logic       err_clr,
  input  logic       w_valid,
  output logic       w_ready,
  input  logic       d_valid,
  output logic       d_ready,
  output logic       res_valid,
  input  logic       res_ready,
  input  logic       new_weight_rdy,
  output logic       new_weight_push,
  input  logic       data_in_rdy,
  output logic       data_in_push,
  input  logic       acc_out_rdy,
  output logic       acc_out_pop,
  input  logic       weight_ld_rdy,
  output logic       weight_ld_start,
  input  logic       weight_ld_done,
  output logic       weight_swap,
  input  logic       mult_rdy,
  output logic       mult_start,
  input  logic       mult_done,
  output logic [3:0] results_pending
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WLD_REQ  = 3'd1,
    S_WLD_WAIT = 3'd2,
    S_SWAP     = 3'd3,
    S_MM_REQ   = 3'd4,
    S_MM_WAIT  = 3'd5,
    S_ERR      = 3'd6
  } state_e;

  localparam logic [1:0]  OP_LOAD_W = 2'b01;
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        rsv_done_q, rsv_done_d;
  logic [3:0]  pend_q, pend_d;
  logic        done_now_s;

  // Stream pass-throughs, independent of FSM state and reset
  assign w_ready         = new_weight_rdy;
  assign new_weight_push = w_valid & new_weight_rdy;
  assign d_ready         = data_in_rdy;
  assign data_in_push    = d_valid & data_in_rdy;
  assign res_valid       = acc_out_rdy;
  assign acc_out_pop     = acc_out_rdy & res_ready;

  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign err             = err_q;
  assign cmd_done        = done_now_s | rsv_done_q;
  assign results_pending = pend_q;

  // Next-state, strobes and timeout counter
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    tmo_d           = 16'd0;
    err_d           = err_q;
    rsv_done_d      = 1'b0;
    done_now_s      = 1'b0;
    weight_ld_start = 1'b0;
    weight_swap     = 1'b0;
    mult_start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          case (cmd_op)
            2'b01, 2'b11: state_d = S_WLD_REQ;
            2'b10:        state_d = S_MM_REQ;
            default:      rsv_done_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WLD_REQ: begin
        if (weight_ld_rdy) begin
          weight_ld_start = 1'b1;
          state_d         = S_WLD_WAIT;
        end else begin
          state_d = S_WLD_REQ;
        end
      end
      S_WLD_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        // A done on the final allowed cycle still wins over the timeout
        if (weight_ld_done) begin
          if (op_q == OP_LOAD_W) begin
            state_d    = S_IDLE;
            done_now_s = 1'b1;
          end else begin
            state_d = S_SWAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_WLD_WAIT;
        end
      end
      S_SWAP: begin
        weight_swap = 1'b1;
        state_d     = S_MM_REQ;
      end
      S_MM_REQ: begin
        if (mult_rdy) begin
          mult_start = 1'b1;
          state_d    = S_MM_WAIT;
        end else begin
          state_d = S_MM_REQ;
        end
      end
      S_MM_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        if (mult_done) begin
          state_d    = S_IDLE;
          done_now_s = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_MM_WAIT;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Saturating count of completed but unread results
  always_comb begin
    pend_d = pend_q;
    case ({mult_done, acc_out_pop})
      2'b10: begin
        if (pend_q != 4'd15) begin
          pend_d = pend_q + 4'd1;
        end else begin
          pend_d = pend_q;
        end
      end
      2'b01: begin
        if (pend_q != 4'd0) begin
          pend_d = pend_q - 4'd1;
        end else begin
          pend_d = pend_q;
        end
      end
      default: pend_d = pend_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      tmo_q      <= 16'd0;
      err_q      <= 1'b0;
      rsv_done_q <= 1'b0;
      pend_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rsv_done_q <= rsv_done_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: doc/mmu_ctrl.md
MMU_CTRL -- requirements
Module: mmu_ctrl

Interface
REQ-001: Parameter TIMEOUT, default 4096, sets the maximum cycles allowed in any wait-for-done state before the block flags an error.
REQ-002: Ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003: Command ports:
- cmd_valid  in  1  command offered.
- cmd_op  in  2  01=LOAD_W, 10=MULT, 11=LOAD_SWAP_MULT, 00=reserved.
- cmd_ready  out  1  command accepted when cmd_valid is also high.
- cmd_done  out  1  one-cycle pulse when a command completes.
- busy  out  1  high when the FSM is not in IDLE.
- err  out  1  sticky error flag.
- err_clr  in  1  clears err and returns the FSM to IDLE.
REQ-004: Weight stream: w_valid in 1, w_ready out 1.
REQ-005: Data stream: d_valid in 1, d_ready out 1.
REQ-006: Result stream: res_valid out 1, res_ready in 1.
REQ-007: MMU-side ports:
- new_weight_rdy in, new_weight_push out.
- data_in_rdy in, data_in_push out.
- acc_out_rdy in, acc_out_pop out.
- weight_ld_rdy in, weight_ld_start out, weight_ld_done in, weight_swap out.
- mult_rdy in, mult_start out, mult_done in.
- All of these are 1 bit.
REQ-008: results_pending  out  4  count of completed mults whose results have not yet been popped.

Function
REQ-009: Streams pass through combinationally:
- w_ready=new_weight_rdy; new_weight_push=w_valid&new_weight_rdy.
- d_ready=data_in_rdy; data_in_push=d_valid&data_in_rdy.
- res_valid=acc_out_rdy; acc_out_pop=res_valid&res_ready.
- The streams are independent of FSM state, including ERR.
REQ-010: FSM states are IDLE, WLD_REQ, WLD_WAIT, SWAP, MM_REQ, MM_WAIT, ERR.
REQ-011: cmd_ready shall be 1 only in IDLE.
REQ-012: A command is accepted on any cycle where cmd_valid&cmd_ready is high.
REQ-013: In IDLE, an accepted LOAD_W or LOAD_SWAP_MULT goes to WLD_REQ.
REQ-014: In IDLE, an accepted MULT goes to MM_REQ.
REQ-015: In IDLE, an accepted op 00 is consumed and pulses cmd_done next cycle with no MMU activity.
REQ-016: WLD_REQ:
- Asserts weight_ld_start combinationally when weight_ld_rdy=1, then goes to WLD_WAIT next cycle.
- Otherwise waits indefinitely (no timeout).
REQ-017: WLD_WAIT exits on weight_ld_done:
- LOAD_W goes to IDLE with cmd_done pulsed that cycle.
- LOAD_SWAP_MULT goes to SWAP.
REQ-018: SWAP asserts weight_swap for exactly one cycle, then goes to MM_REQ.
REQ-019: MM_REQ asserts mult_start when mult_rdy=1, then goes to MM_WAIT; otherwise it waits.
REQ-020: MM_WAIT goes to IDLE on mult_done, with cmd_done pulsed that cycle.
REQ-021: weight_ld_start, weight_swap and mult_start shall each be high for exactly one cycle per command, and never simultaneously.
REQ-022: The timeout counter (16 bits) clears on entry to WLD_WAIT or MM_WAIT and increments each cycle in those states.
REQ-023: If the timeout counter reaches TIMEOUT-1 without a done, the FSM goes to ERR, sets err, and produces no cmd_done.
REQ-024: A done arriving on the same cycle the counter hits TIMEOUT-1 counts as success.
REQ-025: ERR holds cmd_ready=0 and drives no MMU strobes.
REQ-026: err_clr in ERR returns the FSM to IDLE and clears err next cycle; err_clr in other states is ignored.
REQ-027: weight_ld_done or mult_done received outside its matching WAIT state is ignored by the FSM and shall not set err.
REQ-028: results_pending:
- +1 on mult_done (any state), -1 on acc_out_pop.
- Both on the same cycle leaves it unchanged.
- Saturates at 15 and at 0.
REQ-029: The latency from command acceptance to the first strobe is 1 cycle minimum (state register, then a strobe gated by rdy).

Reset
REQ-030: While rst_n=0:
- FSM=IDLE, err=0, timeout counter=0, results_pending=0.
- cmd_done=0, weight_ld_start=0, weight_swap=0, mult_start=0.
REQ-031: Reset mid-command abandons the command with no cmd_done; a later done from the MMU is ignored per REQ-027.
REQ-032: Pass-through outputs follow their inputs during reset.

Verification
REQ-033: The bench shall cover these directed scenarios:
- LOAD_W, weight_ld_rdy=1 at cycle 1, done at cycle 5 -> weight_ld_start pulse at cycle 1, cmd_done at cycle 5, busy cycles 1-5.
- LOAD_SWAP_MULT, all rdy=1, done pulses 3 cycles after each start -> order is start, swap, mult_start; single cmd_done; results_pending=1.
- MULT with mult_done withheld and TIMEOUT=8 -> err=1 after 8 MM_WAIT cycles, cmd_ready=0; err_clr -> IDLE with cmd_ready=1.
- 16 mult_done pulses with res_ready=0 -> results_pending=15; one pop together with one mult_done -> stays 15.
- rst_n=0 during MM_WAIT, then a late mult_done -> no cmd_done, err=0, results_pending=1.
